// File: rtl/hub75_bcm_driver.sv
// HUB75 LED-matrix scan driver with binary-code modulation.
// Shifts one bit-plane per row, latches it, then lights it for BASE_OE<<plane cycles.
module hub75_bcm_driver #(
   parameter int COLS      = 64,
   parameter int ADDR_BITS = 4,
   parameter int BPC       = 4,
   parameter int CLK_DIV   = 2,
   parameter int BASE_OE   = 8,
   parameter int BLANK     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   output logic                     rd_en,
   output logic [ADDR_BITS-1:0]     rd_row,
   output logic [$clog2(COLS)-1:0]  rd_col,
   input  logic [3*BPC-1:0]         rd_data_top,
   input  logic [3*BPC-1:0]         rd_data_bot,
   output logic [ADDR_BITS-1:0]     addr,
   output logic                     R0,
   output logic                     G0,
   output logic                     B0,
   output logic                     R1,
   output logic                     G1,
   output logic                     B1,
   output logic                     SCLK,
   output logic                     LAT,
   output logic                     OE,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int CW       = $clog2(COLS);
   localparam int YW       = $clog2(2*CLK_DIV);
   localparam int PW       = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int DISP_MAX = BASE_OE << (BPC-1);
   localparam int TMAX     = (DISP_MAX > BLANK) ? DISP_MAX : BLANK;
   localparam int TW       = $clog2(TMAX+1);

   typedef enum logic [2:0] {IDLE, SHIFT, BLANKING, LATCH, DISPLAY} state_t;

   state_t               state, state_nx;
   logic [YW-1:0]        cyc;
   logic [CW-1:0]        col;
   logic [TW-1:0]        tmr;
   logic [TW-1:0]        disp_len;
   logic [PW-1:0]        plane;
   logic [ADDR_BITS-1:0] row;
   logic [5:0]           rgb, rgb_q;
   logic                 slot_end, shift_end, blank_end, disp_end;
   logic                 last_plane, last_row;
   logic [BPC-1:0]       tr, tg, tb, br, bg, bb;

   always_comb begin
      disp_len   = TW'(BASE_OE) << plane;
      slot_end   = (cyc == YW'(2*CLK_DIV-1));
      shift_end  = slot_end && (col == CW'(COLS-1));
      blank_end  = (tmr == TW'(BLANK-1));
      disp_end   = (tmr == disp_len - TW'(1));
      last_plane = (plane == PW'(BPC-1));
      last_row   = (row == '1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      frame_done = 1'b0;
      unique case (state)
         IDLE:     if (en) state_nx = SHIFT;
         SHIFT:    if (shift_end) state_nx = BLANKING;
         BLANKING: if (blank_end) state_nx = LATCH;
         LATCH:    state_nx = DISPLAY;
         DISPLAY: begin
            if (disp_end) begin
               frame_done = last_plane && last_row;
               // en only matters at the frame boundary
               state_nx   = (frame_done && !en) ? IDLE : SHIFT;
            end
         end
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc   <= '0;
         col   <= '0;
         tmr   <= '0;
         plane <= '0;
         row   <= '0;
         addr  <= '0;
         rgb_q <= '0;
      end else begin
         rgb_q <= rgb;
         case (state)
            IDLE: begin
               cyc   <= '0;
               col   <= '0;
               tmr   <= '0;
               plane <= '0;
               row   <= '0;
            end
            SHIFT: begin
               cyc <= slot_end ? '0 : cyc + YW'(1);
               if (slot_end) col <= shift_end ? '0 : col + CW'(1);
               if (shift_end) begin
                  addr <= row;
                  tmr  <= '0;
               end
            end
            BLANKING: tmr <= blank_end ? '0 : tmr + TW'(1);
            LATCH:    tmr <= '0;
            DISPLAY: begin
               if (disp_end) begin
                  tmr <= '0;
                  if (last_plane) begin
                     plane <= '0;
                     row   <= row + ADDR_BITS'(1);
                  end else begin
                     plane <= plane + PW'(1);
                  end
               end else begin
                  tmr <= tmr + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      tr = rd_data_top[3*BPC-1 -: BPC];
      tg = rd_data_top[2*BPC-1 -: BPC];
      tb = rd_data_top[BPC-1:0];
      br = rd_data_bot[3*BPC-1 -: BPC];
      bg = rd_data_bot[2*BPC-1 -: BPC];
      bb = rd_data_bot[BPC-1:0];
      // read data arrives the cycle after rd_en; pass it straight through, then hold
      rgb = rgb_q;
      if (state == SHIFT && cyc == YW'(1))
         rgb = {tr[plane], tg[plane], tb[plane], br[plane], bg[plane], bb[plane]};
      {R0, G0, B0, R1, G1, B1} = rgb;
   end

   always_comb begin
      rd_en  = (state == SHIFT) && (cyc == '0);
      rd_row = row;
      rd_col = col;
      SCLK   = (state == SHIFT) && (cyc >= YW'(CLK_DIV));
      LAT    = (state == LATCH);
      OE     = (state != DISPLAY);
      busy   = (state != IDLE);
   end

endmodule

// File: doc/hub75_bcm_driver.md
Name: hub75_bcm_driver

Overview:
Parametrised HUB75 LED-matrix scan driver. It is the successor to the fixed-size panel control block. It supports generic panel width, row-address width and colour depth, and uses binary-code modulation (BCM) for per-pixel intensity. It reads pixel pairs (top and bottom half) from an external synchronous frame buffer and drives the panel's address, colour, shift-clock, latch and output-enable pins.

Parameters:
COLS, 64, pixels per row shifted per plane (>=2)
ADDR_BITS, 4, row-address width; panel has 2*2^ADDR_BITS rows
BPC, 4, bits per colour channel (BCM planes)
CLK_DIV, 2, clk cycles per SCLK half-period (>=2)
BASE_OE, 8, OE-low clk cycles for plane 0; plane p displays BASE_OE<<p
BLANK, 2, OE-high clk cycles before latch (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  run enable
rd_en  out  1  frame-buffer read strobe
rd_row  out  ADDR_BITS  row of requested pixel pair
rd_col  out  clog2(COLS)  column of requested pixel pair
rd_data_top  in  3*BPC  {R,G,B} of top-half pixel, valid 1 cycle after rd_en
rd_data_bot  in  3*BPC  {R,G,B} of bottom-half pixel, valid 1 cycle after rd_en
addr  out  ADDR_BITS  panel row address (A,B,C,D...)
R0 G0 B0  out  1 each  top-half colour bits
R1 G1 B1  out  1 each  bottom-half colour bits
SCLK  out  1  panel shift clock
LAT  out  1  panel latch
OE  out  1  panel output enable, active-low
busy  out  1  high while not IDLE
frame_done  out  1  one-cycle pulse at end of last plane of last row

Behaviour:
- Reset (rst=0, asynchronous): OE=1, LAT=0, SCLK=0, rd_en=0, addr=0, rd_row=0, rd_col=0, colour outputs=0, busy=0, frame_done=0. Internal state returns to IDLE with row=0, plane=0. Reset takes effect immediately, without waiting for a clock edge, including mid-DISPLAY.
- FSM states: IDLE, SHIFT, BLANKING, LATCH, DISPLAY.
- IDLE: OE=1. Enters SHIFT (row 0, plane 0) on the first clk with en=1.
- SHIFT: COLS column slots, each 2*CLK_DIV cycles long. Within the slot for column c:
  - slot cycle 0: rd_en=1, rd_col=c, rd_row=row, SCLK=0.
  - slot cycle 1: R0=top[2*BPC+p], G0=top[BPC+p], B0=top[p]; same mapping from bottom onto R1/G1/B1.
  - cycles CLK_DIV..2*CLK_DIV-1: SCLK=1.
  - rd_en=0 in all other cycles. Colour outputs hold until the next slot's cycle 1.
  - Duration: COLS*2*CLK_DIV cycles, giving exactly COLS SCLK rising edges.
- BLANKING: BLANK cycles with OE=1 and SCLK=0. addr is loaded with row on the first BLANKING cycle.
- LATCH: 1 cycle with LAT=1 and OE=1.
- DISPLAY: OE=0 for exactly BASE_OE<<p cycles.
- Sequencing after DISPLAY:
  - if p<BPC-1: p++ and go to SHIFT.
  - else p=0 and row++.
  - if row wrapped from 2^ADDR_BITS-1 to 0: frame_done=1 for that cycle. Then go to SHIFT if en=1, else IDLE.
- OE is never low outside DISPLAY. LAT is never high while OE=0.
- en=0 mid-frame: the current frame completes, then the block enters IDLE. en is sampled only at frame end.
- Period per row: BPC*(COLS*2*CLK_DIV + BLANK + 1) + BASE_OE*(2^BPC - 1) cycles.
- Period per frame: 2^ADDR_BITS times the row period.
- Counters wrap as stated. No other arithmetic. The OE counter width must hold BASE_OE<<(BPC-1).

Test Plan:
All scenarios use COLS=4, ADDR_BITS=1, BPC=2, CLK_DIV=2, BASE_OE=4, BLANK=2. The row period is 50 cycles and the frame period is 100 cycles.

1. Reset: hold rst=0 with en=1 -> OE=1, LAT=0, SCLK=0, addr=0, all colour outputs 0, busy=0.
2. Shift data: rd_data_top=6'b10_01_11 and rd_data_bot=6'b01_10_00 constant, en=1.
   - Plane 0 -> R0=0, G0=1, B0=1; R1=1, G1=0, B1=0.
   - Plane 1 -> R0=1, G0=0, B0=1; R1=0, G1=1, B1=0.
   - Exactly 4 SCLK rising edges per plane.
   - rd_col sequence is 0,1,2,3, with rd_en high 1 cycle per slot.
3. OE/LAT timing:
   - OE is low exactly 4 cycles for plane 0 and exactly 8 cycles for plane 1.
   - LAT pulses 1 cycle, preceded by 2 OE-high BLANKING cycles.
   - A checker asserting OE=0 implies LAT=0 and SCLK=0 never fires.
4. Frame wrap: run 3 frames.
   - frame_done pulses every 100 cycles.
   - addr sequence per frame is 0,0,1,1 (per plane), then back to 0.
5. Enable drop: deassert en at cycle 30 of a frame.
   - The frame completes and frame_done pulses.
   - The block then enters IDLE with busy=0 and OE=1.
   - Re-asserting en restarts at row 0, plane 0.
6. Async reset mid-DISPLAY: drive rst=0 between clk edges while OE=0.
   - OE goes to 1 before the next edge.
   - After release with en=1, the first rd_row/rd_col read is 0/0.
